// File: rtl/fdivsqrt_ctrl.sv
// rtl/fdivsqrt_ctrl.sv - divide/sqrt iteration sequencer with early termination and result hold
module fdivsqrt_ctrl #(
    parameter int DIVB   = 59,
    parameter int DURLEN = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidE,
    input  logic              SpecialCaseE,
    input  logic              FlushE,
    input  logic [DURLEN-1:0] IterCountE,
    input  logic [DIVB+3:0]   FirstWS,
    input  logic [DIVB+3:0]   FirstWC,
    input  logic [DIVB:0]     FirstU,
    input  logic [DIVB:0]     FirstUM,
    input  logic              ResultAckE,
    output logic              IFDivStartE,
    output logic              FDivBusyE,
    output logic              StallE,
    output logic              DoneE,
    output logic [DIVB:0]     QmE,
    output logic              NegRemE,
    output logic              StickyE
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [DURLEN-1:0] COUNT_ONE = {{(DURLEN-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [DURLEN-1:0] count_q, count_d;
    logic [DIVB:0]     qm_q, qm_d;
    logic              neg_rem_q, neg_rem_d;
    logic              sticky_q, sticky_d;

    logic [DIVB+3:0]   w_sum;
    logic              w_zero;
    logic              w_neg;
    logic              count_zero;
    logic              start;
    logic              busy;

    // Carry-save residual resolved to a single value; wraps modulo the residual width.
    assign w_sum      = FirstWS + FirstWC;
    assign w_zero     = (w_sum == '0);
    assign w_neg      = w_sum[DIVB+3];
    assign count_zero = (count_q == '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        qm_d      = qm_q;
        neg_rem_d = neg_rem_q;
        sticky_d  = sticky_q;
        start     = 1'b0;
        busy      = 1'b0;

        if (FlushE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ValidE) begin
                        if (SpecialCaseE) begin
                            qm_d      = '0;
                            neg_rem_d = 1'b0;
                            sticky_d  = 1'b0;
                            state_d   = S_DONE;
                        end else begin
                            start   = 1'b1;
                            busy    = 1'b1;
                            count_d = IterCountE;
                            state_d = S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (!count_zero && !w_zero) begin
                        busy    = 1'b1;
                        count_d = count_q - COUNT_ONE;
                    end else if (!count_zero) begin
                        // Exact zero residual: U is already the exact result.
                        qm_d      = FirstU;
                        neg_rem_d = 1'b0;
                        sticky_d  = 1'b0;
                        state_d   = S_DONE;
                    end else begin
                        qm_d      = w_neg ? FirstUM : FirstU;
                        neg_rem_d = w_neg;
                        sticky_d  = ~w_zero;
                        state_d   = S_DONE;
                    end
                end
                S_DONE: begin
                    if (ResultAckE) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            qm_q      <= '0;
            neg_rem_q <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            qm_q      <= qm_d;
            neg_rem_q <= neg_rem_d;
            sticky_q  <= sticky_d;
        end
    end

    assign IFDivStartE = start;
    assign FDivBusyE   = busy;
    assign StallE      = (state_q != S_IDLE);
    assign DoneE       = (state_q == S_DONE);
    assign QmE         = qm_q;
    assign NegRemE     = neg_rem_q;
    assign StickyE     = sticky_q;

endmodule

// File: tb/tb_fdivsqrt_ctrl.sv
// tb/tb_fdivsqrt_ctrl.sv - directed-vector bench for fdivsqrt_ctrl with DIVB=8
module tb_fdivsqrt_ctrl;

    logic        clk;
    logic        reset;
    logic        ValidE;
    logic        SpecialCaseE;
    logic        FlushE;
    logic [4:0]  IterCountE;
    logic [11:0] FirstWS;
    logic [11:0] FirstWC;
    logic [8:0]  FirstU;
    logic [8:0]  FirstUM;
    logic        ResultAckE;
    logic        IFDivStartE;
    logic        FDivBusyE;
    logic        StallE;
    logic        DoneE;
    logic [8:0]  QmE;
    logic        NegRemE;
    logic        StickyE;

    int vectors;
    int miscompares;

    fdivsqrt_ctrl #(.DIVB(8), .DURLEN(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .ValidE      (ValidE),
        .SpecialCaseE(SpecialCaseE),
        .FlushE      (FlushE),
        .IterCountE  (IterCountE),
        .FirstWS     (FirstWS),
        .FirstWC     (FirstWC),
        .FirstU      (FirstU),
        .FirstUM     (FirstUM),
        .ResultAckE  (ResultAckE),
        .IFDivStartE (IFDivStartE),
        .FDivBusyE   (FDivBusyE),
        .StallE      (StallE),
        .DoneE       (DoneE),
        .QmE         (QmE),
        .NegRemE     (NegRemE),
        .StickyE     (StickyE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply to the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag, input logic [8:0] q, input logic neg, input logic sticky);
        check({tag, "_done"},   64'(DoneE),   64'd1);
        check({tag, "_qm"},     64'(QmE),     64'(q));
        check({tag, "_negrem"}, 64'(NegRemE), 64'(neg));
        check({tag, "_sticky"}, 64'(StickyE), 64'(sticky));
    endtask

    task automatic ack_to_idle(input string tag);
        ResultAckE = 1'b1;
        tick();
        ResultAckE = 1'b0;
        #1;
        check({tag, "_idle_stall"}, 64'(StallE), 64'd0);
        check({tag, "_idle_done"},  64'(DoneE),  64'd0);
    endtask

    // Start at t0 with N=3; residual given is held for the whole operation (nonzero).
    task automatic normal_op(input string tag, input logic [11:0] ws, input logic [8:0] q,
                             input logic neg, input logic sticky);
        FirstWS = ws; FirstWC = 12'h000; FirstU = 9'h155; FirstUM = 9'h154;
        ValidE = 1'b1; IterCountE = 5'd3;
        #1;
        check({tag, "_start_t0"}, 64'(IFDivStartE), 64'd1);
        check({tag, "_busy_t0"},  64'(FDivBusyE),   64'd1);
        tick();
        ValidE = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check({tag, "_start_tn"}, 64'(IFDivStartE), 64'd0);
            check({tag, "_busy_tn"},  64'(FDivBusyE),   64'd1);
            check({tag, "_stall_tn"}, 64'(StallE),      64'd1);
            tick();
        end
        #1;
        check({tag, "_busy_t4"}, 64'(FDivBusyE), 64'd0);
        check({tag, "_done_t4"}, 64'(DoneE),     64'd0);
        tick();
        check_result({tag, "_t5"}, q, neg, sticky);
        ack_to_idle(tag);
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; ValidE = 1'b0; SpecialCaseE = 1'b0; FlushE = 1'b0; IterCountE = 5'd0;
        FirstWS = 12'h0; FirstWC = 12'h0; FirstU = 9'h0; FirstUM = 9'h0; ResultAckE = 1'b0;
        tick(); tick();
        reset = 1'b0;
        #1;
        check("rst_stall",  64'(StallE),      64'd0);
        check("rst_done",   64'(DoneE),       64'd0);
        check("rst_start",  64'(IFDivStartE), 64'd0);
        check("rst_busy",   64'(FDivBusyE),   64'd0);
        check("rst_qm",     64'(QmE),         64'd0);
        check("rst_negrem", 64'(NegRemE),     64'd0);
        check("rst_sticky", 64'(StickyE),     64'd0);

        normal_op("normal", 12'h010, 9'h155, 1'b0, 1'b1);
        normal_op("negrem", 12'hFF0, 9'h154, 1'b1, 1'b1);

        // Special case: no iteration, zeroed result replaces the previous 0x154
        ValidE = 1'b1; SpecialCaseE = 1'b1;
        #1;
        check("spec_start", 64'(IFDivStartE), 64'd0);
        check("spec_busy",  64'(FDivBusyE),   64'd0);
        tick();
        ValidE = 1'b0; SpecialCaseE = 1'b0;
        check_result("spec_t1", 9'h000, 1'b0, 1'b0);
        ack_to_idle("spec");

        // Early termination: residual sum wraps to zero at t2 while Count is still > 0
        FirstWS = 12'h010; FirstWC = 12'h000; FirstU = 9'h0AA; FirstUM = 9'h0A9;
        ValidE = 1'b1; IterCountE = 5'd6;
        tick();
        ValidE = 1'b0;
        #1;
        check("early_busy_t1", 64'(FDivBusyE), 64'd1);
        tick();
        FirstWS = 12'h0F0; FirstWC = 12'hF10;
        #1;
        check("early_busy_t2", 64'(FDivBusyE), 64'd0);
        tick();
        FirstU = 9'h1FF; FirstWS = 12'h010; FirstWC = 12'h000;
        check_result("early_t3", 9'h0AA, 1'b0, 1'b0);
        tick();
        check("early_hold_qm", 64'(QmE), 64'h0AA);
        ack_to_idle("early");

        // Flush at t2 of an N=5 operation: back to IDLE, result registers untouched
        ValidE = 1'b1; IterCountE = 5'd5;
        tick();
        ValidE = 1'b0;
        tick();
        FlushE = 1'b1;
        #1;
        check("flush_busy_t2",  64'(FDivBusyE),   64'd0);
        check("flush_start_t2", 64'(IFDivStartE), 64'd0);
        tick();
        FlushE = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("flush_stall", 64'(StallE), 64'd0);
            check("flush_done",  64'(DoneE),  64'd0);
            tick();
        end
        check("flush_qm", 64'(QmE), 64'h0AA);

        // Reset at t2 of an N=5 operation clears the result too
        ValidE = 1'b1; IterCountE = 5'd5;
        tick();
        ValidE = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rstmid_stall", 64'(StallE), 64'd0);
        check("rstmid_done",  64'(DoneE),  64'd0);
        check("rstmid_qm",    64'(QmE),    64'd0);
        check("rstmid_busy",  64'(FDivBusyE), 64'd0);

        // IterCountE=0: one BUSY cycle latches initial values; then hold with ValidE pulsing
        FirstWS = 12'h001; FirstWC = 12'h000; FirstU = 9'h133; FirstUM = 9'h132;
        ValidE = 1'b1; IterCountE = 5'd0;
        #1;
        check("zero_busy_t0", 64'(FDivBusyE), 64'd1);
        tick();
        ValidE = 1'b0;
        #1;
        check("zero_busy_t1", 64'(FDivBusyE), 64'd0);
        check("zero_stall_t1", 64'(StallE), 64'd1);
        tick();
        check_result("zero_t2", 9'h133, 1'b0, 1'b1);
        FirstU = 9'h0F0;
        for (int i = 0; i < 3; i++) begin
            ValidE = (i != 1);
            #1;
            check("hold_done",  64'(DoneE),       64'd1);
            check("hold_qm",    64'(QmE),         64'h133);
            check("hold_start", 64'(IFDivStartE), 64'd0);
            check("hold_busy",  64'(FDivBusyE),   64'd0);
            tick();
        end
        ValidE = 1'b0;
        ack_to_idle("hold");

        ValidE = 1'b1; IterCountE = 5'd1;
        #1;
        check("restart_start", 64'(IFDivStartE), 64'd1);
        tick();
        ValidE = 1'b0;
        #1;
        check("restart_busy", 64'(FDivBusyE), 64'd1);
        tick(); tick();
        check("restart_done", 64'(DoneE), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
